display_share_scheduler: RTL

Time-shares the 4-digit seven-segment display between two requesters. A round-robin arbiter grants display ownership. The owner's 16-bit binary value is converted to 4-digit BCD by a sequential shift-add-3 engine. The digits are then scanned onto the anodes at the refresh rate. The block sits between value producers (counters, blink/status logic) and the cathode decoder, which consumes `digit_bcd`.

---
 rtl/display_share_scheduler.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/display_share_scheduler.sv
// Round-robin time-sharing of a 4-digit seven-segment display between two clients,
// with clamped double-dabble BCD conversion and anode scan. Option: LEADING_ZERO_BLANK_EN.
module display_share_scheduler #(
  parameter int REFRESH_BITS = 20,
  parameter int HOLD_CYCLES  = 100000000
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [15:0] value0,
  input  logic [15:0] value1,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        overflow,
  output logic [3:0]  Anode_Activate,
  output logic [3:0]  digit_bcd
);

  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, CONVERT, SHOW} state_t;

  state_t                  state_q,    state_d;
  logic                    sel_q,      sel_d;
  logic                    last_q,     last_d;
  logic [1:0]              grant_q,    grant_d;
  logic                    busy_q,     busy_d;
  logic                    overflow_q, overflow_d;
  logic [31:0]             shift_q,    shift_d;
  logic [3:0]              iter_q,     iter_d;
  logic [15:0]             disp_q,     disp_d;
  logic [TW-1:0]           timer_q,    timer_d;
  logic [REFRESH_BITS-1:0] scan_q,     scan_d;

  logic [15:0] cap_raw;
  logic [15:0] cap_val;
  logic        cap_over;
  logic [31:0] adj;
  logic [31:0] shift_next;
  logic [1:0]  digit_sel;

  // Winner's value, clamped to the largest 4-digit number.
  always_comb begin
    cap_raw  = sel_q ? value1 : value0;
    cap_over = (cap_raw > 16'd9999);
    cap_val  = cap_over ? 16'd9999 : cap_raw;
  end

  // One double-dabble step: BCD lives in [31:16], the binary operand shifts out of [15:0].
  always_comb begin
    adj = shift_q;
    for (int i = 0; i < 4; i++) begin
      if (shift_q[16 + 4*i +: 4] >= 4'd5)
        adj[16 + 4*i +: 4] = shift_q[16 + 4*i +: 4] + 4'd3;
    end
    shift_next = adj << 1;
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    overflow_d = overflow_q;
    shift_d    = shift_q;
    iter_d     = iter_q;
    disp_d     = disp_q;
    timer_d    = timer_q;
    scan_d     = scan_q + REFRESH_BITS'(1);

    case (state_q)
      IDLE: begin
        grant_d = 2'b00;
        if (|req) begin
          state_d = CAPTURE;
          sel_d   = (req == 2'b11) ? ~last_q : req[1];
        end
      end
      CAPTURE: begin
        grant_d    = sel_q ? 2'b10 : 2'b01;
        last_d     = sel_q;
        overflow_d = cap_over;
        shift_d    = {16'd0, cap_val};
        iter_d     = 4'd0;
        busy_d     = 1'b1;
        state_d    = CONVERT;
      end
      CONVERT: begin
        shift_d = shift_next;
        iter_d  = iter_q + 4'd1;
        // The display only ever sees a finished conversion.
        if (iter_q == 4'd15) begin
          disp_d  = shift_next[31:16];
          busy_d  = 1'b0;
          timer_d = '0;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (!req[last_q]) begin
          grant_d = 2'b00;
          state_d = IDLE;
        end else if (timer_q == HOLD_LAST) begin
          sel_d   = req[~last_q] ? ~last_q : last_q;
          state_d = CAPTURE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      last_q     <= 1'b1;
      grant_q    <= 2'b00;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      shift_q    <= '0;
      iter_q     <= '0;
      disp_q     <= '0;
      timer_q    <= '0;
      scan_q     <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      shift_q    <= shift_d;
      iter_q     <= iter_d;
      disp_q     <= disp_d;
      timer_q    <= timer_d;
      scan_q     <= scan_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;
  assign digit_sel = scan_q[REFRESH_BITS-1 -: 2];

  always_comb begin
    Anode_Activate = 4'b1111;
    digit_bcd      = 4'd0;
    case (digit_sel)
      2'd0: begin Anode_Activate = 4'b0111; digit_bcd = disp_q[15:12]; end
      2'd1: begin Anode_Activate = 4'b1011; digit_bcd = disp_q[11:8];  end
      2'd2: begin Anode_Activate = 4'b1101; digit_bcd = disp_q[7:4];   end
      default: begin Anode_Activate = 4'b1110; digit_bcd = disp_q[3:0]; end
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every digit to its left are zero; units always lit.
    case (digit_sel)
      2'd0: if (disp_q[15:12] == 4'd0) Anode_Activate = 4'b1111;
      2'd1: if (disp_q[15:8]  == 8'd0) Anode_Activate = 4'b1111;
      2'd2: if (disp_q[15:4]  == 12'd0) Anode_Activate = 4'b1111;
      default: ;
    endcase
`endif
  end

endmodule
